// File: rtl/c64_dma_responder.sv
// C64 expansion-port DMA responder: turns a toggle-handshake request into one
// C64 bus cycle by pulling /DMA, waiting out VIC steals, then driving the bus.
module c64_dma_responder #(
    parameter int ADDR_DLY = 1,
    parameter int DATA_DLY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dma_a,
    input  logic [7:0]  dma_d,
    input  logic        dma_rw,
    input  logic        dma_req,
    output logic        dma_ack,
    output logic [7:0]  dma_q,
    input  logic        phi2,
    input  logic        ba,
    output logic        dma_n,
    output logic [15:0] bus_a,
    output logic        bus_a_oe,
    output logic        bus_rw,
    output logic        bus_rw_oe,
    input  logic [7:0]  bus_d_in,
    output logic [7:0]  bus_d_out,
    output logic        bus_d_oe
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ARM     = 3'd1;
    localparam logic [2:0] GRANT   = 3'd2;
    localparam logic [2:0] WAIT_HI = 3'd3;
    localparam logic [2:0] CYC     = 3'd4;

    localparam logic [8:0] ADDR_DUE = 9'(ADDR_DLY);
    localparam logic [8:0] DATA_DUE = 9'(DATA_DLY);

    logic       phi2_meta, phi2_sync, phi2_last;
    logic       ba_meta, ba_sync;
    logic [7:0] d_meta, d_sync;

    logic [2:0]  state;
    logic [7:0]  cnt;
    logic [15:0] lat_a;
    logic [7:0]  lat_d;
    logic        lat_rw;
    logic        d_oe_q;

    logic phi2_rise, phi2_fall, pending, addr_due, data_due;

    always_ff @(posedge clk) begin
        if (reset) begin
            phi2_meta <= 1'b0;
            phi2_sync <= 1'b0;
            phi2_last <= 1'b0;
            ba_meta   <= 1'b0;
            ba_sync   <= 1'b0;
            d_meta    <= 8'h00;
            d_sync    <= 8'h00;
        end else begin
            phi2_meta <= phi2;
            phi2_sync <= phi2_meta;
            phi2_last <= phi2_sync;
            ba_meta   <= ba;
            ba_sync   <= ba_meta;
            d_meta    <= bus_d_in;
            d_sync    <= d_meta;
        end
    end

    assign phi2_rise = phi2_sync & ~phi2_last;
    assign phi2_fall = ~phi2_sync & phi2_last;
    assign pending   = dma_req != dma_ack;
    // cnt holds the clks elapsed since the rise, so the next edge is cnt+1
    assign addr_due  = ({1'b0, cnt} + 9'd1) >= ADDR_DUE;
    assign data_due  = ({1'b0, cnt} + 9'd1) >= DATA_DUE;

    // Data drive is gated combinationally so it drops the moment the
    // synchronised phi2 goes low, a clk before the fall is acted upon.
    assign bus_d_oe = d_oe_q & phi2_sync & ~bus_rw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dma_ack   <= dma_req;
            dma_q     <= 8'h00;
            dma_n     <= 1'b1;
            bus_a     <= 16'h0000;
            bus_a_oe  <= 1'b0;
            bus_rw    <= 1'b1;
            bus_rw_oe <= 1'b0;
            bus_d_out <= 8'h00;
            d_oe_q    <= 1'b0;
            cnt       <= 8'h00;
            lat_a     <= 16'h0000;
            lat_d     <= 8'h00;
            lat_rw    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        lat_a  <= dma_a;
                        lat_d  <= dma_d;
                        lat_rw <= dma_rw;
                        state  <= ARM;
                    end
                end
                ARM: begin
                    if (phi2_fall) begin
                        dma_n <= 1'b0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (phi2_fall && ba_sync) begin
                        state <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (phi2_rise && ba_sync) begin
                        cnt   <= 8'h00;
                        state <= CYC;
                    end
                end
                CYC: begin
                    if (phi2_fall) begin
                        if (!lat_rw) begin
                            dma_q <= d_sync;
                        end
                        dma_ack   <= ~dma_ack;
                        bus_a_oe  <= 1'b0;
                        bus_rw_oe <= 1'b0;
                        bus_rw    <= 1'b1;
                        d_oe_q    <= 1'b0;
                        // req equal to the old ack means it differs from the new one
                        if (dma_req == dma_ack) begin
                            lat_a  <= dma_a;
                            lat_d  <= dma_d;
                            lat_rw <= dma_rw;
                            state  <= WAIT_HI;
                        end else begin
                            dma_n <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        if (cnt != 8'hFF) begin
                            cnt <= cnt + 8'd1;
                        end
                        if (addr_due) begin
                            bus_a     <= lat_a;
                            bus_rw    <= ~lat_rw;
                            bus_a_oe  <= 1'b1;
                            bus_rw_oe <= 1'b1;
                        end
                        if (data_due && lat_rw) begin
                            bus_d_out <= lat_d;
                            d_oe_q    <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c64_dma_responder.sv
// Bench for c64_dma_responder: a free-running phi2 at 1/16 clk, a scoreboard of
// expected transfers, and a monitor that records each completed bus cycle.
module tb_c64_dma_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] dma_a = 16'h0000;
    logic [7:0]  dma_d = 8'h00;
    logic        dma_rw = 1'b0;
    logic        dma_req = 1'b1;
    logic        dma_ack;
    logic [7:0]  dma_q;
    logic        phi2 = 1'b0;
    logic        ba = 1'b1;
    logic        dma_n;
    logic [15:0] bus_a;
    logic        bus_a_oe;
    logic        bus_rw;
    logic        bus_rw_oe;
    logic [7:0]  bus_d_in = 8'h00;
    logic [7:0]  bus_d_out;
    logic        bus_d_oe;

    c64_dma_responder #(.ADDR_DLY(1), .DATA_DLY(4)) dut (
        .clk(clk), .reset(reset),
        .dma_a(dma_a), .dma_d(dma_d), .dma_rw(dma_rw), .dma_req(dma_req),
        .dma_ack(dma_ack), .dma_q(dma_q),
        .phi2(phi2), .ba(ba), .dma_n(dma_n),
        .bus_a(bus_a), .bus_a_oe(bus_a_oe), .bus_rw(bus_rw), .bus_rw_oe(bus_rw_oe),
        .bus_d_in(bus_d_in), .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #3;
        forever #80 phi2 = ~phi2;
    end

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;
        logic [7:0]  q;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic        rw_bus;
        logic [7:0]  d_out;
        logic        d_seen;
        int          d_delay;
        logic [7:0]  q;
        int          aoe_fcnt;
        int          aoe_rcnt;
        int          ack_fcnt;
        logic        dma_n_after;
    } obs_t;

    exp_t sb[$];
    obs_t obs_q[$];
    logic [7:0] model_q = 8'h00;

    int checks = 0;
    int errors = 0;

    int clk_cnt = 0, rise_cnt = 0, fall_cnt = 0;
    int dman_falls = 0, dman_rises = 0, grant_fcnt = 0;
    int ack_toggles = 0, rw_conflicts = 0, steal_drives = 0;
    logic phi2_prev = 1'b0, dma_n_prev = 1'b1, aoe_prev = 1'b0, doe_prev = 1'b0;
    logic ack_prev = 1'b1;
    logic [15:0] cur_a = 16'h0000;
    logic cur_rw = 1'b1, cur_dseen = 1'b0;
    logic [7:0] cur_d = 8'h00;
    int cur_aoe_clk = 0, cur_doe_clk = 0, cur_aoe_fcnt = 0, cur_aoe_rcnt = 0;

    // Monitor: counts phi2 edges, notes when drivers come up, and files one
    // observation per ack toggle for the test tasks to compare.
    always @(negedge clk) begin : mon
        obs_t o;
        clk_cnt   <= clk_cnt + 1;
        phi2_prev <= phi2;
        if (phi2 && !phi2_prev) rise_cnt <= rise_cnt + 1;
        if (!phi2 && phi2_prev) fall_cnt <= fall_cnt + 1;
        dma_n_prev <= dma_n;
        if (!dma_n && dma_n_prev) begin
            dman_falls <= dman_falls + 1;
            grant_fcnt <= fall_cnt;
        end
        if (dma_n && !dma_n_prev) dman_rises <= dman_rises + 1;
        aoe_prev <= bus_a_oe;
        doe_prev <= bus_d_oe;
        if (bus_a_oe && !aoe_prev) begin
            cur_a        <= bus_a;
            cur_rw       <= bus_rw;
            cur_aoe_clk  <= clk_cnt;
            cur_aoe_fcnt <= fall_cnt;
            cur_aoe_rcnt <= rise_cnt;
        end
        if (bus_d_oe && !doe_prev) begin
            cur_d       <= bus_d_out;
            cur_dseen   <= 1'b1;
            cur_doe_clk <= clk_cnt;
        end
        if (bus_d_oe && bus_rw) rw_conflicts <= rw_conflicts + 1;
        if ((bus_a_oe || bus_rw_oe || bus_d_oe) && !ba) steal_drives <= steal_drives + 1;
        ack_prev <= dma_ack;
        if (reset) begin
            cur_dseen <= 1'b0;
        end else if (dma_ack != ack_prev) begin
            ack_toggles   <= ack_toggles + 1;
            o.a           = cur_a;
            o.rw_bus      = cur_rw;
            o.d_out       = cur_d;
            o.d_seen      = cur_dseen;
            o.d_delay     = cur_doe_clk - cur_aoe_clk;
            o.q           = dma_q;
            o.aoe_fcnt    = cur_aoe_fcnt;
            o.aoe_rcnt    = cur_aoe_rcnt;
            o.ack_fcnt    = fall_cnt;
            o.dma_n_after = dma_n;
            obs_q.push_back(o);
            cur_dseen <= 1'b0;
        end
    end

    task automatic issue(input logic [15:0] a, input logic [7:0] d, input logic rw,
                         input logic [7:0] rd);
        exp_t e;
        dma_a    = a;
        dma_d    = d;
        dma_rw   = rw;
        bus_d_in = rd;
        if (!rw) model_q = rd;
        e.a  = a;
        e.d  = d;
        e.rw = rw;
        e.q  = model_q;
        sb.push_back(e);
        dma_req = ~dma_req;
    endtask

    task automatic test_reset;
        repeat (4) @(negedge clk);
        checks++; if (dma_ack !== 1'b1) begin errors++; $display("[TB] FAIL reset_ack got=%b want=1", dma_ack); end
        checks++; if (dma_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_dma_n got=%b want=1", dma_n); end
        checks++; if ({bus_a_oe, bus_rw_oe, bus_d_oe} !== 3'b000) begin errors++; $display("[TB] FAIL reset_oe got=%b want=000", {bus_a_oe, bus_rw_oe, bus_d_oe}); end
        checks++; if (bus_a !== 16'h0000) begin errors++; $display("[TB] FAIL reset_bus_a got=%h want=0000", bus_a); end
        checks++; if (bus_rw !== 1'b1) begin errors++; $display("[TB] FAIL reset_bus_rw got=%b want=1", bus_rw); end
        checks++; if (bus_d_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_bus_d_out got=%h want=00", bus_d_out); end
        checks++; if (dma_q !== 8'h00) begin errors++; $display("[TB] FAIL reset_dma_q got=%h want=00", dma_q); end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (dma_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle_dma_n got=%b want=1", dma_n); end
    endtask

    task automatic test_read;
        int base_f, base_ack;
        exp_t e;
        obs_t o;
        @(posedge phi2);
        @(negedge clk);
        base_f   = fall_cnt;
        base_ack = ack_toggles;
        issue(16'hD020, 8'h00, 1'b0, 8'h5A);
        for (int i = 0; i < 200 && obs_q.size() == 0; i++) @(negedge clk);
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL read_timeout got=none want=ack"); return; end
        o = obs_q.pop_front();
        e = sb.pop_front();
        checks++; if (grant_fcnt - base_f != 1) begin errors++; $display("[TB] FAIL read_grant_fall got=%0d want=1", grant_fcnt - base_f); end
        checks++; if (o.aoe_fcnt - base_f != 2) begin errors++; $display("[TB] FAIL read_cycle_phase got=%0d want=2", o.aoe_fcnt - base_f); end
        checks++; if (o.ack_fcnt - base_f != 3) begin errors++; $display("[TB] FAIL read_ack_fall got=%0d want=3", o.ack_fcnt - base_f); end
        checks++; if (o.a !== e.a || o.rw_bus !== ~e.rw) begin errors++; $display("[TB] FAIL read_bus got=%h/%b want=%h/%b", o.a, o.rw_bus, e.a, ~e.rw); end
        checks++; if (o.d_seen !== 1'b0) begin errors++; $display("[TB] FAIL read_no_data_drive got=%b want=0", o.d_seen); end
        checks++; if (o.q !== e.q) begin errors++; $display("[TB] FAIL read_dma_q got=%h want=%h", o.q, e.q); end
        checks++; if (o.dma_n_after !== 1'b1) begin errors++; $display("[TB] FAIL read_dma_n_release got=%b want=1", o.dma_n_after); end
        repeat (40) @(negedge clk);
        checks++; if (ack_toggles - base_ack != 1) begin errors++; $display("[TB] FAIL read_ack_once got=%0d want=1", ack_toggles - base_ack); end
    endtask

    task automatic test_write;
        exp_t e;
        obs_t o;
        @(posedge phi2);
        @(negedge clk);
        issue(16'h0400, 8'h41, 1'b1, 8'hA5);
        for (int i = 0; i < 200 && obs_q.size() == 0; i++) @(negedge clk);
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL write_timeout got=none want=ack"); return; end
        o = obs_q.pop_front();
        e = sb.pop_front();
        checks++; if (o.a !== 16'h0400 || o.rw_bus !== 1'b0) begin errors++; $display("[TB] FAIL write_bus got=%h/%b want=0400/0", o.a, o.rw_bus); end
        checks++; if (o.d_seen !== 1'b1 || o.d_out !== e.d) begin errors++; $display("[TB] FAIL write_data got=%b/%h want=1/%h", o.d_seen, o.d_out, e.d); end
        checks++; if (o.d_delay != 3) begin errors++; $display("[TB] FAIL write_data_delay got=%0d want=3", o.d_delay); end
        checks++; if (o.q !== e.q) begin errors++; $display("[TB] FAIL write_dma_q_held got=%h want=%h", o.q, e.q); end
        checks++; if ({bus_a_oe, bus_rw_oe, bus_d_oe} !== 3'b000) begin errors++; $display("[TB] FAIL write_release got=%b want=000", {bus_a_oe, bus_rw_oe, bus_d_oe}); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int base_rises, base_falls;
        exp_t e;
        obs_t o[2];
        @(posedge phi2);
        @(negedge clk);
        base_rises = dman_rises;
        base_falls = dman_falls;
        issue(16'h1234, 8'h00, 1'b0, 8'hC3);
        for (int i = 0; i < 200 && !bus_a_oe; i++) @(negedge clk);
        checks++;
        if (!bus_a_oe) begin errors++; $display("[TB] FAIL b2b_first_cycle got=idle want=drive"); return; end
        issue(16'hD800, 8'h07, 1'b1, 8'hC3);
        for (int i = 0; i < 300 && obs_q.size() < 2; i++) @(negedge clk);
        checks++;
        if (obs_q.size() < 2) begin errors++; $display("[TB] FAIL b2b_timeout got=%0d want=2", obs_q.size()); return; end
        for (int k = 0; k < 2; k++) begin
            o[k] = obs_q.pop_front();
            e = sb.pop_front();
            checks++; if (o[k].a !== e.a || o[k].rw_bus !== ~e.rw) begin errors++; $display("[TB] FAIL b2b_bus%0d got=%h/%b want=%h/%b", k, o[k].a, o[k].rw_bus, e.a, ~e.rw); end
            checks++; if (o[k].q !== e.q) begin errors++; $display("[TB] FAIL b2b_dma_q%0d got=%h want=%h", k, o[k].q, e.q); end
        end
        checks++; if (o[0].dma_n_after !== 1'b0) begin errors++; $display("[TB] FAIL b2b_dma_n_held got=%b want=0", o[0].dma_n_after); end
        checks++; if (o[1].aoe_rcnt - o[0].aoe_rcnt != 1) begin errors++; $display("[TB] FAIL b2b_consecutive got=%0d want=1", o[1].aoe_rcnt - o[0].aoe_rcnt); end
        checks++; if (o[1].d_seen !== 1'b1 || o[1].d_out !== 8'h07) begin errors++; $display("[TB] FAIL b2b_write_data got=%b/%h want=1/07", o[1].d_seen, o[1].d_out); end
        repeat (4) @(negedge clk);
        checks++; if (dman_rises - base_rises != 1 || dman_falls - base_falls != 1) begin errors++; $display("[TB] FAIL b2b_dma_n_edges got=%0d/%0d want=1/1", dman_falls - base_falls, dman_rises - base_rises); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_vic_steal;
        int base_f, base_steal, rcnt_ba;
        exp_t e;
        obs_t o;
        @(posedge phi2);
        @(negedge clk);
        base_f     = fall_cnt;
        base_steal = steal_drives;
        issue(16'hD012, 8'h00, 1'b0, 8'h99);
        for (int i = 0; i < 200 && dma_n; i++) @(negedge clk);
        checks++;
        if (dma_n) begin errors++; $display("[TB] FAIL vic_grant_timeout got=1 want=0"); return; end
        ba = 1'b0;
        repeat (3) @(negedge phi2);
        @(posedge phi2);
        repeat (2) @(negedge clk);
        rcnt_ba = rise_cnt;
        ba = 1'b1;
        for (int i = 0; i < 200 && obs_q.size() == 0; i++) @(negedge clk);
        checks++;
        if (obs_q.size() == 0) begin errors++; $display("[TB] FAIL vic_timeout got=none want=ack"); return; end
        o = obs_q.pop_front();
        e = sb.pop_front();
        checks++; if (steal_drives != base_steal) begin errors++; $display("[TB] FAIL vic_drive_while_ba_low got=%0d want=0", steal_drives - base_steal); end
        checks++; if (o.aoe_rcnt != rcnt_ba + 1) begin errors++; $display("[TB] FAIL vic_first_rise got=%0d want=%0d", o.aoe_rcnt, rcnt_ba + 1); end
        checks++; if (o.aoe_fcnt - base_f != 5) begin errors++; $display("[TB] FAIL vic_grant_hold got=%0d want=5", o.aoe_fcnt - base_f); end
        checks++; if (o.q !== e.q || o.a !== e.a) begin errors++; $display("[TB] FAIL vic_result got=%h/%h want=%h/%h", o.a, o.q, e.a, e.q); end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid_cycle;
        int base_ack;
        @(posedge phi2);
        @(negedge clk);
        issue(16'h2000, 8'hEE, 1'b1, 8'h00);
        for (int i = 0; i < 200 && !bus_d_oe; i++) @(negedge clk);
        checks++;
        if (!bus_d_oe) begin errors++; $display("[TB] FAIL rst_mid_timeout got=0 want=bus_d_oe"); return; end
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if ({bus_a_oe, bus_rw_oe, bus_d_oe} !== 3'b000) begin errors++; $display("[TB] FAIL rst_mid_oe got=%b want=000", {bus_a_oe, bus_rw_oe, bus_d_oe}); end
        checks++; if (dma_n !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_dma_n got=%b want=1", dma_n); end
        checks++; if (dma_ack !== dma_req) begin errors++; $display("[TB] FAIL rst_mid_ack got=%b want=%b", dma_ack, dma_req); end
        sb.delete();
        model_q = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        base_ack = ack_toggles;
        repeat (60) @(negedge clk);
        checks++; if (dma_n !== 1'b1 || ack_toggles != base_ack) begin errors++; $display("[TB] FAIL rst_mid_idle got=%b/%0d want=1/0", dma_n, ack_toggles - base_ack); end
        checks++; if (dma_q !== model_q) begin errors++; $display("[TB] FAIL rst_mid_dma_q got=%h want=%h", dma_q, model_q); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL rst_mid_spurious_ack got=%0d want=0", obs_q.size()); end
    endtask

    task automatic test_double_toggle;
        int base_ack, base_falls;
        @(negedge clk);
        base_ack   = ack_toggles;
        base_falls = dman_falls;
        dma_req = ~dma_req;
        #2;
        dma_req = ~dma_req;
        repeat (48) @(negedge clk);
        checks++; if (dman_falls != base_falls || dma_n !== 1'b1) begin errors++; $display("[TB] FAIL dbl_dma_n got=%0d/%b want=0/1", dman_falls - base_falls, dma_n); end
        checks++; if (ack_toggles != base_ack) begin errors++; $display("[TB] FAIL dbl_ack got=%0d want=0", ack_toggles - base_ack); end
    endtask

    task automatic test_invariants;
        checks++; if (rw_conflicts != 0) begin errors++; $display("[TB] FAIL d_oe_while_read got=%0d want=0", rw_conflicts); end
        checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_left got=%0d want=0", sb.size()); end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write;
        test_back_to_back;
        test_vic_steal;
        test_reset_mid_cycle;
        test_double_toggle;
        test_invariants;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout got=running want=done");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule

// File: doc/c64_dma_responder.md
C64_DMA_RESPONDER -- requirements
Module: c64_dma_responder

Interface
REQ-001 Parameter ADDR_DLY, default 1: clk cycles after a detected phi2 rise before address and rw are driven.
REQ-002 Parameter DATA_DLY, default 4: clk cycles after a detected phi2 rise before write data is driven.
REQ-003 clk  in  1  system clock, at least 16x phi2.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 dma_a  in  16  requested C64 address.
REQ-006 dma_d  in  8  write data.
REQ-007 dma_rw  in  1  direction: 1 = write to C64, 0 = read from C64.
REQ-008 dma_req  in  1  toggle request.
REQ-009 dma_ack  out  1  toggle acknowledge.
REQ-010 dma_q  out  8  read data.
REQ-011 phi2  in  1  asynchronous C64 phi2.
REQ-012 ba  in  1  asynchronous C64 BA.
REQ-013 dma_n  out  1  C64 /DMA, active-low.
REQ-014 bus_a  out  16  expansion-port address.
REQ-015 bus_a_oe  out  1  address driver enable.
REQ-016 bus_rw  out  1  C64 R/W (1 = read).
REQ-017 bus_rw_oe  out  1  R/W driver enable.
REQ-018 bus_d_in  in  8  data bus input.
REQ-019 bus_d_out  out  8  data bus output.
REQ-020 bus_d_oe  out  1  data driver enable.

Function
REQ-021 The block SHALL treat a request as pending whenever dma_req != dma_ack; it SHALL latch dma_a, dma_d and dma_rw when it accepts the request.
REQ-022 phi2, ba and bus_d_in SHALL each pass through an identical 2-flop synchroniser; phi2 rise and fall SHALL be detected on the synchronised copy.
REQ-023 The state machine SHALL have states IDLE, ARM, GRANT, WAIT_HI, CYC.
REQ-024 IDLE -> ARM when a request is pending.
REQ-025 ARM -> GRANT on the next phi2 fall, driving dma_n = 0 in the same cycle.
REQ-026 GRANT -> WAIT_HI on the next phi2 fall seen with synchronised ba = 1; a fall with ba = 0 SHALL keep the block in GRANT.
REQ-027 WAIT_HI -> CYC on phi2 rise if ba = 1; if ba = 0, the block SHALL stay in WAIT_HI for the next rise (VIC steal).
REQ-028 In CYC, ADDR_DLY clks after the rise, the block SHALL assert bus_a = latched address, bus_rw = ~latched dma_rw, and bus_a_oe = bus_rw_oe = 1.
REQ-029 For writes, DATA_DLY clks after the rise, the block SHALL assert bus_d_out = latched data and bus_d_oe = 1.
REQ-030 On the phi2 fall in CYC, the block SHALL: capture dma_q from synchronised bus_d_in (reads only; dma_q unchanged on writes), toggle dma_ack, and deassert bus_a_oe, bus_rw_oe and bus_d_oe.
REQ-031 On that same fall, if a new request is already pending (dma_req != the new ack value), the block SHALL latch it, keep dma_n = 0, and go to WAIT_HI; otherwise it SHALL set dma_n = 1 and go to IDLE.
REQ-032 dma_q SHALL be valid no later than the clk edge at which dma_ack toggles, and SHALL hold until the next read completes.
REQ-033 The block SHALL ignore a request toggle arriving mid-cycle until the current cycle completes; a double toggle (req returns to ack) SHALL be treated as no request.
REQ-034 bus_d_oe SHALL never be 1 while bus_rw = 1 or phi2 (synchronised) = 0.

Reset
REQ-035 Reset SHALL give: dma_ack <= dma_req (any pending request discarded), dma_n = 1, all *_oe = 0, bus_a = 0, bus_rw = 1, bus_d_out = 0, dma_q = 0, state = IDLE.
REQ-036 Reset mid-cycle SHALL release all drivers and dma_n on the next clk edge without toggling dma_ack further.

Verification
REQ-037 Read: req toggle, dma_a = 0xD020, dma_rw = 0, bus returns 0x5A -> dma_n low on the first phi2 fall, cycle in the next-but-one phi2 high, dma_q = 0x5A, ack toggles exactly once, dma_n high.
REQ-038 Write: dma_a = 0x0400, dma_d = 0x41, dma_rw = 1 -> bus_a = 0x0400, bus_rw = 0, bus_d_out = 0x41 with oe from rise+4 clk to the fall, dma_q unchanged.
REQ-039 Back-to-back: a second request toggled within 2 clk of the first ack -> no dma_n deassertion between cycles, two consecutive phi2-high cycles used.
REQ-040 VIC steal: ba = 0 for 3 phi2 periods after grant -> no bus drive while ba = 0, cycle completes on the first rise with ba = 1.
REQ-041 Reset asserted in CYC with bus_d_oe = 1 -> all oe = 0 and dma_n = 1 after one clk, dma_ack == dma_req, IDLE.
REQ-042 Double toggle of req in IDLE within one clk -> no dma_n assertion and no ack toggle.
